mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the lab RISC-V CPU.
- Decodes the instruction opcode and sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUop consumed by the ALU function decoder, plus all datapath enables and mux selects.
- Waits on a memory-ready handshake in every memory-access state.

Parameters:
- OP_W, 7, opcode width
- IMEM_WAIT_MAX, 0, 0 = unbounded wait; otherwise a watchdog count (valid only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- opcode  in  7  instr[6:0] from the IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if zero
- i_or_d  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1
- mem_write  out  1
- ir_write  out  1
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  00 regB, 01 const 4, 10 imm
- alu_op  out  2  00/10 add, 01 sub, 11 funct-decoded
- pc_source  out  1  0 = ALU result, 1 = ALUOut
- illegal  out  1  only with the optional feature; otherwise tied 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset forces state to IF. While rst is high, all write/read enables (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are 0, all selects are 0, and alu_op is 00.
- Output style: Moore decode from the state register, except pc_write and ir_write in IF, which equal mem_ready.
- Opcodes: R 0110011, I-arith 0010011, LW 0000011, SW 0100011, BEQ 1100011, JAL 1101111.
- IF: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=10, pc_source=0. Stays in IF until mem_ready, then goes to ID. PC+4 and the IR load occur in the mem_ready cycle.
- ID: src_a=0, src_b=10, alu_op=10, so ALUOut = PC+imm. PC already holds PC+4, so the branch target is computed with the immediate offset. Next state by opcode:
  - R -> EX_R
  - I-arith -> EX_I
  - LW/SW -> EX_ADDR
  - BEQ -> EX_BR
  - JAL -> EX_JAL
  - others -> IF (or ILL with the feature)
- EX_R: src_a=1, src_b=00, alu_op=11 -> WB_ALU.
- EX_I: src_a=1, src_b=10, alu_op=11 -> WB_ALU.
- EX_ADDR: src_a=1, src_b=10, alu_op=10 -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then -> WB_MEM.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then -> IF. mem_write stays high for every wait cycle.
- WB_ALU: reg_write=1, mem_to_reg=00 -> IF.
- WB_MEM: reg_write=1, mem_to_reg=01 -> IF.
- EX_BR: src_a=1, src_b=00, alu_op=01, pc_write_cond=1, pc_source=1 -> IF. With zero=0 the PC keeps PC+4.
- EX_JAL: pc_write=1, pc_source=1, reg_write=1, mem_to_reg=10 (rd <- PC, i.e. old PC+4) -> IF.
- Instruction latencies: R/I 4 cycles, SW 4, LW 5, BEQ/JAL 3. Each mem_ready=0 cycle adds one.
- Reset mid-instruction: abandons the instruction; no partial reg_write or mem_write after rst rises.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in ID -> ILL state. ILL is sticky: all enables 0, illegal=1, exits only via rst.
  - IMEM_WAIT_MAX>0 -> a fetch waiting more than IMEM_WAIT_MAX cycles also enters ILL.
- Undefined: unknown opcode returns to IF silently, illegal is tied 0, and no watchdog counter is built.

Decomposition:
- Package mc_pkg:
  - state enum
  - opcode localparams
  - ALUOP_ADD=2'b10, ALUOP_SUB=2'b01, ALUOP_FUNC=2'b11
  - SRCB_REG/FOUR/IMM
  - MEM2REG_ALU/MDR/PC
- No sub-module required. The optional wait watchdog counter may stay inline.

Test Plan:
- Reset asserted mid-EX_R, released -> state IF and reg_write never pulses; first fetch with mem_ready=1 gives pc_write=1 and ir_write=1.
- R-type add (0110011), mem_ready always 1 -> 4 cycles with alu_op sequence 10, 10, 11, then reg_write=1 with mem_to_reg=00.
- LW with mem_ready low 3 cycles in MEM_RD -> mem_read and i_or_d held for 4 cycles; WB_MEM reg_write=1, mem_to_reg=01; total 8 cycles.
- BEQ zero=1 vs zero=0 -> EX_BR alu_op=01 and pc_write_cond=1 in both cases, pc_write=0; 3 cycles total.
- JAL -> EX_JAL pc_write=1, pc_source=1, reg_write=1, mem_to_reg=10, then IF.
- Opcode 1111111 -> without the macro, next state IF; with MC_ILLEGAL_TRAP_EN, illegal=1 held and enables 0 until rst.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle main control FSM.
//   state_e        - controller states
//   OP_*           - RV32 major opcodes recognised in ID
//   ALUOP_*        - ALUop codes handed to the ALU function decoder
//   SRCB_*         - ALU operand-B mux selects
//   MEM2REG_*      - register-file write-data mux selects
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_EX_BR   = 4'd9,
        S_EX_JAL  = 4'd10,
        S_ILL     = 4'd11
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_NONE = 2'b00;
    localparam logic [1:0] ALUOP_ADD  = 2'b10;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] MEM2REG_ALU = 2'b00;
    localparam logic [1:0] MEM2REG_MDR = 2'b01;
    localparam logic [1:0] MEM2REG_PC  = 2'b10;

endpackage

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle main control FSM for the lab RISC-V CPU.
// Sequences IF -> ID -> EX -> (MEM) -> (WB), waiting on mem_ready in every
// memory-access state.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset (state -> IF)
//   opcode         instr[6:0] from the IR (stable after the fetch)
//   zero           ALU zero flag (branch resolution happens in the datapath
//                  through pc_write_cond, so the FSM itself does not need it)
//   mem_ready      memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
//                  datapath enables / mux selects (Moore decode, except
//                  pc_write and ir_write in IF follow mem_ready)
//   illegal        trap indication (only with MC_ILLEGAL_TRAP_EN)
//
// Build option MC_ILLEGAL_TRAP_EN: unknown opcodes and (IMEM_WAIT_MAX>0)
// overlong fetch waits enter a sticky ILL state left only through rst.
// Without it unknown opcodes silently return to IF and illegal stays 0.
module mc_main_control
    import mc_pkg::*;
#(
    parameter int OP_W          = 7,
    parameter int IMEM_WAIT_MAX = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic [1:0]      mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            pc_source,
    output logic            illegal
);

    state_e state, state_nxt;
    state_e bad_op_state;
    logic   wd_trip;

    logic unused_zero;
    assign unused_zero = zero;

`ifdef MC_ILLEGAL_TRAP_EN
    assign bad_op_state = S_ILL;

    // Counts consecutive fetch wait cycles; trips on the wait cycle that
    // would exceed IMEM_WAIT_MAX.
    localparam int WD_W = (IMEM_WAIT_MAX > 0) ? $clog2(IMEM_WAIT_MAX + 1) : 1;
    logic [WD_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == S_IF && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign wd_trip = (IMEM_WAIT_MAX > 0) && (state == S_IF) && !mem_ready &&
                     (wait_cnt == WD_W'(IMEM_WAIT_MAX));
`else
    localparam int unused_wait_max = IMEM_WAIT_MAX;
    assign bad_op_state = S_IF;
    assign wd_trip      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IF;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IF: begin
                if (wd_trip)
                    state_nxt = S_ILL;
                else if (mem_ready)
                    state_nxt = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_R:          state_nxt = S_EX_R;
                    OP_I:          state_nxt = S_EX_I;
                    OP_LW, OP_SW:  state_nxt = S_EX_ADDR;
                    OP_BEQ:        state_nxt = S_EX_BR;
                    OP_JAL:        state_nxt = S_EX_JAL;
                    default:       state_nxt = bad_op_state;
                endcase
            end
            S_EX_R, S_EX_I:   state_nxt = S_WB_ALU;
            // IR is only reloaded in IF, so the opcode is still valid here.
            S_EX_ADDR:        state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:         if (mem_ready) state_nxt = S_WB_MEM;
            S_MEM_WR:         if (mem_ready) state_nxt = S_IF;
            S_WB_ALU, S_WB_MEM, S_EX_BR, S_EX_JAL:
                              state_nxt = S_IF;
            S_ILL:            state_nxt = S_ILL;
            default:          state_nxt = S_IF;
        endcase
    end

    // Output decode; everything is forced quiet while rst is high so no
    // partial write escapes an abandoned instruction.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = MEM2REG_ALU;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_NONE;
        pc_source     = 1'b0;
        illegal       = 1'b0;
        if (!rst) begin
            case (state)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALUOP_ADD;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                S_ID: begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_ADD;
                end
                S_EX_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNC;
                end
                S_EX_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNC;
                end
                S_EX_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_ALU: begin
                    reg_write  = 1'b1;
                    mem_to_reg = MEM2REG_ALU;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = MEM2REG_MDR;
                end
                S_EX_BR: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                end
                S_EX_JAL: begin
                    // PC already holds old PC+4, which is the link value.
                    pc_write   = 1'b1;
                    pc_source  = 1'b1;
                    reg_write  = 1'b1;
                    mem_to_reg = MEM2REG_PC;
                end
`ifdef MC_ILLEGAL_TRAP_EN
                S_ILL: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: an instruction-level model (kind, step within
// the instruction, latency table) predicts the control word every cycle;
// directed steps additionally pin hand-computed control words.
// Control word layout: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
// ir_write, mem_to_reg[1:0], reg_write, alu_src_a, alu_src_b[1:0],
// alu_op[1:0], pc_source, illegal}.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       pc_source, illegal;

    mc_main_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] dut_vec;
    assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal};

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_BAD = 6;

    int          total = 0;
    int          bad   = 0;
    int          m_step = 0;
    logic        lit_en;
    logic [15:0] lit_val;
    string       lit_name;

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            default:    return K_BAD;
        endcase
    endfunction

    // Cycles per instruction with no memory waits.
    function automatic int ilen(input int k);
        case (k)
            K_R, K_I, K_SW: return 4;
            K_LW:           return 5;
            K_BR, K_JAL:    return 3;
`ifdef MC_ILLEGAL_TRAP_EN
            default:        return 3;
`else
            default:        return 2;
`endif
        endcase
    endfunction

    function automatic logic [15:0] mk(input logic pw, pwc, iod, mr, mw, irw,
                                       input logic [1:0] m2r, input logic rw, sa,
                                       input logic [1:0] sb, aop,
                                       input logic pcs, ill);
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, sa, sb, aop, pcs, ill};
    endfunction

    // Required control word for step s of an instruction of kind k.
    function automatic logic [15:0] exp_vec(input int k, input int s, input logic rdy);
        if (s == 0) return mk(rdy,0,0,1,0,rdy, 2'b00,0,0, 2'b01,2'b10, 0,0);
        if (s == 1) return mk(0,0,0,0,0,0, 2'b00,0,0, 2'b10,2'b10, 0,0);
        if (s == 2) begin
            case (k)
                K_R:        return mk(0,0,0,0,0,0, 2'b00,0,1, 2'b00,2'b11, 0,0);
                K_I:        return mk(0,0,0,0,0,0, 2'b00,0,1, 2'b10,2'b11, 0,0);
                K_LW, K_SW: return mk(0,0,0,0,0,0, 2'b00,0,1, 2'b10,2'b10, 0,0);
                K_BR:       return mk(0,1,0,0,0,0, 2'b00,0,1, 2'b00,2'b01, 1,0);
                K_JAL:      return mk(1,0,0,0,0,0, 2'b10,1,0, 2'b00,2'b00, 1,0);
                default:    return 16'h0001;
            endcase
        end
        if (s == 3) begin
            case (k)
                K_LW:    return mk(0,0,1,1,0,0, 2'b00,0,0, 2'b00,2'b00, 0,0);
                K_SW:    return mk(0,0,1,0,1,0, 2'b00,0,0, 2'b00,2'b00, 0,0);
                default: return mk(0,0,0,0,0,0, 2'b00,1,0, 2'b00,2'b00, 0,0);
            endcase
        end
        return mk(0,0,0,0,0,0, 2'b01,1,0, 2'b00,2'b00, 0,0);
    endfunction

    task automatic compare_and_step();
        int          k;
        logic        hold;
        logic [15:0] ev;
        k  = classify(opcode);
        ev = rst ? 16'h0000 : exp_vec(k, m_step, mem_ready);
        total++;
        if (dut_vec !== ev) begin
            bad++;
            $display("FAIL model step=%0d kind=%0d rst=%0b: got %h want %h",
                     m_step, k, rst, dut_vec, ev);
        end
        if (lit_en) begin
            total++;
            if (dut_vec !== lit_val) begin
                bad++;
                $display("FAIL %s: got %h want %h", lit_name, dut_vec, lit_val);
            end
        end
        if (rst) begin
            m_step = 0;
        end else begin
            hold = (m_step == 0 || ((k == K_LW || k == K_SW) && m_step == 3)) && !mem_ready;
`ifdef MC_ILLEGAL_TRAP_EN
            if (k == K_BAD && m_step == 2) hold = 1'b1;
`endif
            if (!hold) m_step = (m_step + 1 == ilen(k)) ? 0 : m_step + 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_and_step();
        end
    end

    // One directed cycle: drive just after the rising edge, optionally pin a
    // literal control word, then let the negedge compare run.
    task automatic cyc(input logic [6:0] op, input logic rdy, input logic z,
                       input logic r, input logic le, input logic [15:0] ev,
                       input string nm);
        @(posedge clk); #1;
        opcode = op; mem_ready = rdy; zero = z; rst = r;
        lit_en = le; lit_val = ev; lit_name = nm;
        @(negedge clk); #1;
    endtask

    localparam logic [6:0] R = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, BD = 7'b1111111;

    logic [6:0] ops [6];

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
        rst = 1'b1; opcode = R; mem_ready = 1'b0; zero = 1'b0;
        lit_en = 1'b1; lit_val = 16'h0000; lit_name = "reset_state";
        @(negedge clk); #1;

        // R-type interrupted by reset in EX_R, then a clean R-type.
        cyc(R, 1, 0, 0, 1, 16'h9418, "r_if_pre");
        cyc(R, 1, 0, 0, 1, 16'h0028, "r_id_pre");
        cyc(R, 1, 0, 1, 1, 16'h0000, "rst_mid_exr");
        cyc(R, 1, 0, 1, 1, 16'h0000, "rst_hold");
        cyc(R, 1, 0, 0, 1, 16'h9418, "post_rst_fetch");
        cyc(R, 1, 0, 0, 1, 16'h0028, "r_id");
        cyc(R, 1, 0, 0, 1, 16'h004C, "r_ex");
        cyc(R, 1, 0, 0, 1, 16'h0080, "r_wb");

        // LW: one fetch wait, then 3 memory waits in MEM_RD.
        cyc(LW, 0, 0, 0, 1, 16'h1018, "if_wait");
        cyc(LW, 1, 0, 0, 1, 16'h9418, "lw_if");
        cyc(LW, 1, 0, 0, 1, 16'h0028, "lw_id");
        cyc(LW, 1, 0, 0, 1, 16'h0068, "lw_addr");
        for (int i = 0; i < 3; i++) cyc(LW, 0, 0, 0, 1, 16'h3000, "lw_mem_wait");
        cyc(LW, 1, 0, 0, 1, 16'h3000, "lw_mem_done");
        cyc(LW, 1, 0, 0, 1, 16'h0180, "lw_wb");

        // BEQ taken / not taken look identical to the controller.
        cyc(BQ, 1, 1, 0, 1, 16'h9418, "beq1_if");
        cyc(BQ, 1, 1, 0, 1, 16'h0028, "beq1_id");
        cyc(BQ, 1, 1, 0, 1, 16'h4046, "beq1_ex");
        cyc(BQ, 1, 0, 0, 1, 16'h9418, "beq0_if");
        cyc(BQ, 1, 0, 0, 1, 16'h0028, "beq0_id");
        cyc(BQ, 1, 0, 0, 1, 16'h4046, "beq0_ex");

        cyc(JL, 1, 0, 0, 1, 16'h9418, "jal_if");
        cyc(JL, 1, 0, 0, 1, 16'h0028, "jal_id");
        cyc(JL, 1, 0, 0, 1, 16'h8282, "jal_ex");

        // SW: mem_write held through a wait cycle.
        cyc(SW, 1, 0, 0, 1, 16'h9418, "sw_if");
        cyc(SW, 1, 0, 0, 1, 16'h0028, "sw_id");
        cyc(SW, 1, 0, 0, 1, 16'h0068, "sw_addr");
        cyc(SW, 0, 0, 0, 1, 16'h2800, "sw_mem_wait");
        cyc(SW, 1, 0, 0, 1, 16'h2800, "sw_mem_done");

        // Unknown opcode.
        cyc(BD, 1, 0, 0, 1, 16'h9418, "bad_if");
        cyc(BD, 1, 0, 0, 1, 16'h0028, "bad_id");
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc(BD, 1, 0, 0, 1, 16'h0001, "ill_sticky");
        cyc(BD, 1, 0, 1, 1, 16'h0000, "ill_rst");
`else
        cyc(R, 1, 0, 0, 1, 16'h9418, "bad_back_to_if");
`endif

        // Randomized traffic; opcode only changes while fetching.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            lit_en    = 1'b0;
            rst       = ($urandom_range(0, 59) == 0);
            mem_ready = ($urandom_range(0, 9) < 7);
            zero      = 1'($urandom);
            if (m_step == 0) begin
                if ($urandom_range(0, 7) == 0) opcode = 7'($urandom);
                else opcode = ops[$urandom_range(0, 5)];
            end
        end
        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
